// File: rtl/code_run_pkg.sv
// rtl/code_run_pkg.sv - shared types and constants for the code run-length encoder
//
// Purpose:
//   State encoding, statistics counter width and the run-length ceiling helper
//   used by code_run_encoder and code_run_stats.
//
// Contents:
//   state_e    - IDLE (no open run) / RUN (run value and count held)
//   STAT_WIDTH - width of the optional statistics counters
//   max_count  - largest representable run length for a given counter width

package code_run_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  localparam int STAT_WIDTH = 16;

  // All-ones value of a count_width-bit counter, i.e. the longest run.
  function automatic int unsigned max_count(input int unsigned count_width);
    return (32'd1 << count_width) - 32'd1;
  endfunction

endpackage

// File: rtl/code_run_stats.sv
// rtl/code_run_stats.sv - saturating symbol and run counters for the encoder
//
// Purpose:
//   Counts accepted codes and output-slot loads. Both counters stop at all-ones
//   instead of wrapping and clear on reset.
//
// Ports:
//   clock        in   rising-edge clock
//   reset        in   synchronous, active-high
//   symbol_inc   in   one code accepted this cycle
//   run_inc      in   one run loaded into the output slot this cycle
//   stat_symbols out  accepted code count
//   stat_runs    out  slot load count

module code_run_stats
  import code_run_pkg::*;
(
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  symbol_inc,
  input  logic                  run_inc,
  output logic [STAT_WIDTH-1:0] stat_symbols,
  output logic [STAT_WIDTH-1:0] stat_runs
);

  logic [STAT_WIDTH-1:0] symbols_q, symbols_d;
  logic [STAT_WIDTH-1:0] runs_q, runs_d;

  always_comb begin
    symbols_d = symbols_q;
    runs_d    = runs_q;
    if (symbol_inc && (symbols_q != '1)) begin
      symbols_d = symbols_q + STAT_WIDTH'(1);
    end
    if (run_inc && (runs_q != '1)) begin
      runs_d = runs_q + STAT_WIDTH'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      symbols_q <= '0;
      runs_q    <= '0;
    end else begin
      symbols_q <= symbols_d;
      runs_q    <= runs_d;
    end
  end

  assign stat_symbols = symbols_q;
  assign stat_runs    = runs_q;

endmodule

// File: rtl/code_run_encoder.sv
// rtl/code_run_encoder.sv - run-length encoder for classifier result codes
//
// Purpose:
//   Collapses consecutive identical codes into (value, count) pairs and presents
//   each completed run through a one-entry valid/ready output register. A run
//   closes on a differing code, on reaching the counter ceiling, or on flush.
//
// Parameters:
//   WIDTH       code width
//   COUNT_WIDTH run-length counter width; longest run is 2^COUNT_WIDTH-1
//
// Ports:
//   clock      in   rising-edge clock
//   reset      in   synchronous, active-high; discards open run and slot
//   in_valid   in   in_data carries a code
//   in_data    in   code from the classifier
//   in_ready   out  code accepted this cycle when in_valid is high
//   flush      in   level request to close and emit the open run
//   out_valid  out  out_value/out_count hold a completed run
//   out_value  out  code of the emitted run
//   out_count  out  length of the emitted run (>= 1)
//   out_ready  in   consumer takes the run this cycle
//   idle       out  no open run and output slot empty
//
// Build option:
//   CODE_RUN_ENCODER_STATS_EN adds stat_symbols / stat_runs (saturating
//   16-bit counters of accepted codes and slot loads). Encoding is unchanged.

module code_run_encoder
  import code_run_pkg::*;
#(
  parameter int WIDTH       = 8,
  parameter int COUNT_WIDTH = 8
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   in_valid,
  input  logic [WIDTH-1:0]       in_data,
  output logic                   in_ready,
  input  logic                   flush,
  output logic                   out_valid,
  output logic [WIDTH-1:0]       out_value,
  output logic [COUNT_WIDTH-1:0] out_count,
  input  logic                   out_ready,
  output logic                   idle
`ifdef CODE_RUN_ENCODER_STATS_EN
  ,
  output logic [STAT_WIDTH-1:0]  stat_symbols,
  output logic [STAT_WIDTH-1:0]  stat_runs
`endif
);

  localparam logic [COUNT_WIDTH-1:0] MAX_RUN = COUNT_WIDTH'(max_count(COUNT_WIDTH));
  localparam logic [COUNT_WIDTH-1:0] ONE     = COUNT_WIDTH'(1);

  state_e                 state_q, state_d;
  logic [WIDTH-1:0]       run_value_q, run_value_d;
  logic [COUNT_WIDTH-1:0] run_count_q, run_count_d;
  logic                   out_valid_q, out_valid_d;
  logic [WIDTH-1:0]       out_value_q, out_value_d;
  logic [COUNT_WIDTH-1:0] out_count_q, out_count_d;

  logic slot_free;
  logic pop;
  logic ready_c;
  logic accept;
  logic load;

  // A pop in the same cycle frees the slot, so a close can reload it without
  // a bubble.
  assign slot_free = !out_valid_q || out_ready;
  assign pop       = out_valid_q && out_ready;

  always_comb begin
    state_d     = state_q;
    run_value_d = run_value_q;
    run_count_d = run_count_q;
    ready_c     = 1'b0;
    load        = 1'b0;

    unique case (state_q)
      IDLE: begin
        ready_c = !flush;
        if (in_valid && ready_c && !reset) begin
          run_value_d = in_data;
          run_count_d = ONE;
          state_d     = RUN;
        end
      end
      RUN: begin
        ready_c = slot_free && !flush;
        if (flush) begin
          // Flush wins over input; it waits here until the slot can take the run.
          if (slot_free) begin
            load    = 1'b1;
            state_d = IDLE;
          end
        end else if (in_valid && ready_c && !reset) begin
          if ((in_data == run_value_q) && (run_count_q != MAX_RUN)) begin
            run_count_d = run_count_q + ONE;
          end else begin
            // Differing code or saturated count: close the run, start a new one.
            load        = 1'b1;
            run_value_d = in_data;
            run_count_d = ONE;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign accept = in_valid && ready_c && !reset;

  always_comb begin
    out_valid_d = out_valid_q;
    out_value_d = out_value_q;
    out_count_d = out_count_q;
    if (load) begin
      out_valid_d = 1'b1;
      out_value_d = run_value_q;
      out_count_d = run_count_q;
    end else if (pop) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= IDLE;
      run_value_q <= '0;
      run_count_q <= '0;
      out_valid_q <= 1'b0;
      out_value_q <= '0;
      out_count_q <= '0;
    end else begin
      state_q     <= state_d;
      run_value_q <= run_value_d;
      run_count_q <= run_count_d;
      out_valid_q <= out_valid_d;
      out_value_q <= out_value_d;
      out_count_q <= out_count_d;
    end
  end

  assign in_ready  = ready_c && !reset;
  assign out_valid = out_valid_q;
  assign out_value = out_value_q;
  assign out_count = out_count_q;
  assign idle      = (state_q == IDLE) && !out_valid_q;

`ifdef CODE_RUN_ENCODER_STATS_EN
  code_run_stats u_stats (
    .clock        (clock),
    .reset        (reset),
    .symbol_inc   (accept),
    .run_inc      (load),
    .stat_symbols (stat_symbols),
    .stat_runs    (stat_runs)
  );
`else
  logic unused_accept;
  assign unused_accept = accept;
`endif

endmodule
